// File: rtl/bcd_dn_timer_ctrl_pkg.sv
// Shared types and helpers for the BCD down-counter interval timer controller.
package bcd_tmr_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_RELOAD
    } state_t;

    localparam int PW_W = 4;

    function automatic logic is_bcd8(input logic [7:0] value);
        return (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9);
    endfunction

endpackage

// File: rtl/bcd_dn_timer_ctrl_if.sv
// Control/status bundle between the timer controller and its surroundings.
// BCD_TMR_DROP_CNT_EN adds the drop_cnt and qz_mismatch diagnostics.
interface bcd_dn_timer_ctrl_if;

    logic       start;
    logic       stop;
    logic       auto_mode;
    logic       tick;
    logic [7:0] preset;
    logic [7:0] cnt_q;
    logic       cnt_cao;
    logic [7:0] cnt_d;
    logic       cnt_ld;
    logic       cnt_en;
    logic       cnt_cai;
    logic       cnt_cs;
    logic       busy;
    logic       expire;
    logic       err;

`ifdef BCD_TMR_DROP_CNT_EN
    logic [7:0] drop_cnt;
    logic       qz_mismatch;

    modport slave (
        input  start, stop, auto_mode, tick, preset, cnt_q, cnt_cao,
        output cnt_d, cnt_ld, cnt_en, cnt_cai, cnt_cs, busy, expire, err,
        output drop_cnt, qz_mismatch
    );

    modport master (
        output start, stop, auto_mode, tick, preset, cnt_q, cnt_cao,
        input  cnt_d, cnt_ld, cnt_en, cnt_cai, cnt_cs, busy, expire, err,
        input  drop_cnt, qz_mismatch
    );
`else
    modport slave (
        input  start, stop, auto_mode, tick, preset, cnt_q, cnt_cao,
        output cnt_d, cnt_ld, cnt_en, cnt_cai, cnt_cs, busy, expire, err
    );

    modport master (
        output start, stop, auto_mode, tick, preset, cnt_q, cnt_cao,
        input  cnt_d, cnt_ld, cnt_en, cnt_cai, cnt_cs, busy, expire, err
    );
`endif

endinterface

// File: rtl/bcd_dn_timer_ctrl_pulse_stretch.sv
// Retriggerable stretcher: a trigger produces a PULSE_W-cycle high output starting next cycle.
module bcd_tmr_pulse_stretch
    import bcd_tmr_pkg::*;
#(
    parameter int unsigned PULSE_W = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic trig,
    output logic pulse
);

    logic [PW_W-1:0] remain;

    // A trigger during an active pulse reloads the full width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remain <= '0;
        end else if (trig) begin
            remain <= PW_W'(PULSE_W);
        end else if (remain != '0) begin
            remain <= remain - PW_W'(1);
        end
    end

    assign pulse = (remain != '0);

endmodule

// File: rtl/bcd_dn_timer_ctrl.sv
// Interval timer sequencer wrapped around a 2-digit BCD down-counter cell.
// Optional diagnostics are built when BCD_TMR_DROP_CNT_EN is defined.
module bcd_dn_timer_ctrl
    import bcd_tmr_pkg::*;
#(
    parameter int unsigned PULSE_W      = 1,
    parameter bit          AUTO_DEFAULT = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bcd_dn_timer_ctrl_if.slave   bus
);

    state_t     state;
    state_t     state_nx;
    logic [7:0] preset_reg;
    logic [7:0] preset_nx;
    logic       mode;
    logic       mode_nx;
    logic       err_q;
    logic       err_nx;
    logic       expire_trig;
    logic       start_accept;
    logic       start_req;
    logic       preset_ok;

    assign start_req = bus.start && !bus.stop;
    assign preset_ok = is_bcd8(bus.preset);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_CLEAR;
            preset_reg <= 8'h00;
            mode       <= AUTO_DEFAULT;
            err_q      <= 1'b0;
        end else begin
            state      <= state_nx;
            preset_reg <= preset_nx;
            mode       <= mode_nx;
            err_q      <= err_nx;
        end
    end

    // STOP outranks everything; a valid restart outranks a coincident terminal count.
    always_comb begin
        state_nx     = state;
        preset_nx    = preset_reg;
        mode_nx      = mode;
        err_nx       = 1'b0;
        expire_trig  = 1'b0;
        start_accept = 1'b0;

        case (state)
            ST_CLEAR: state_nx = ST_IDLE;
            ST_IDLE: begin
                if (bus.stop) begin
                    state_nx = ST_CLEAR;
                end else if (start_req) begin
                    if (preset_ok) begin
                        start_accept = 1'b1;
                        state_nx     = ST_LOAD;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            ST_LOAD: state_nx = bus.stop ? ST_CLEAR : ST_RUN;
            ST_RUN: begin
                if (bus.stop) begin
                    state_nx = ST_CLEAR;
                end else if (start_req && preset_ok) begin
                    start_accept = 1'b1;
                    state_nx     = ST_LOAD;
                end else begin
                    err_nx = start_req;
                    if (bus.cnt_cao) begin
                        expire_trig = 1'b1;
                        state_nx    = mode ? ST_RELOAD : ST_CLEAR;
                    end
                end
            end
            ST_RELOAD: begin
                if (bus.stop) begin
                    state_nx = ST_CLEAR;
                end else if (start_req && preset_ok) begin
                    start_accept = 1'b1;
                    state_nx     = ST_LOAD;
                end else begin
                    err_nx   = start_req;
                    state_nx = ST_RUN;
                end
            end
            default: state_nx = ST_CLEAR;
        endcase

        if (start_accept) begin
            preset_nx = bus.preset;
            mode_nx   = bus.auto_mode;
        end
    end

    bcd_tmr_pulse_stretch #(
        .PULSE_W (PULSE_W)
    ) u_stretch (
        .clk   (clk),
        .rst_n (rst_n),
        .trig  (expire_trig),
        .pulse (bus.expire)
    );

    assign bus.cnt_d   = preset_reg;
    assign bus.cnt_ld  = (state == ST_LOAD) || (state == ST_RELOAD);
    assign bus.cnt_en  = (state == ST_RUN);
    assign bus.cnt_cai = (state == ST_RUN) && bus.tick;
    assign bus.cnt_cs  = (state == ST_CLEAR);
    assign bus.busy    = (state == ST_LOAD) || (state == ST_RUN) || (state == ST_RELOAD);
    assign bus.err     = err_q;

`ifdef BCD_TMR_DROP_CNT_EN
    logic [7:0] drop_q;
    logic       qz_q;

    // Ticks swallowed while the cell is being (re)loaded; saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= 8'h00;
            qz_q   <= 1'b0;
        end else begin
            if (start_accept) begin
                drop_q <= 8'h00;
            end else if (bus.tick && ((state == ST_LOAD) || (state == ST_RELOAD))
                         && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
            qz_q <= (state == ST_RUN) && bus.cnt_cao && (bus.cnt_q != 8'h00);
        end
    end

    assign bus.drop_cnt    = drop_q;
    assign bus.qz_mismatch = qz_q;
`else
    // Q only feeds the optional zero check; keep it visibly consumed here.
    logic unused_cnt_q;
    assign unused_cnt_q = ^bus.cnt_q;
`endif

endmodule

// File: doc/bcd_dn_timer_ctrl.md
Name: bcd_dn_timer_ctrl

Overview:
Sequencing controller that sits directly around a 2-digit (00..99) BCD decade down-counter cell with synchronous clear, load, enable, CAI and CAO. It drives the cell's D/LD/EN/CS/CAI pins, watches its Q and CAO, and turns it into a programmable interval timer with single-shot or auto-reload modes. TICK comes from an upstream prescaler; EXPIRE goes to interrupt/strobe logic.

Parameters:
PULSE_W, 1, EXPIRE pulse width in CLK cycles, legal 1..15
AUTO_DEFAULT, 0, value of the internal mode latch after reset

Ports:
CLK  input  1  system clock, rising edge
RSTN  input  1  asynchronous active-low reset
START  input  1  start/restart request, level-sampled each CLK
STOP  input  1  abort request; wins over START
AUTO  input  1  mode, sampled with START: 1 = auto-reload, 0 = single-shot
TICK  input  1  count strobe, one CLK wide per count
PRESET  input  8  BCD preset {tens, units}
CNT_Q  input  8  counter cell Q7..Q0
CNT_CAO  input  1  counter cell carry-out
CNT_D  output  8  counter cell D7..D0
CNT_LD  output  1  counter cell LD
CNT_EN  output  1  counter cell EN
CNT_CAI  output  1  counter cell CAI
CNT_CS  output  1  counter cell CS
BUSY  output  1  high in LOAD, RUN, RELOAD
EXPIRE  output  1  terminal-count pulse
ERR  output  1  one-cycle pulse: START rejected, PRESET not BCD

Behaviour:
- States: CLEAR, IDLE, LOAD, RUN, RELOAD. Reset state CLEAR. Outputs decoded from registered state/regs.
- Reset (async, any time, mid-count included): state CLEAR, preset reg 00, mode latch AUTO_DEFAULT, CNT_D 00, CNT_LD/EN/CAI 0, CNT_CS 1 (state-decoded), BUSY/EXPIRE/ERR 0, pulse counter 0.
- CLEAR: CNT_CS=1 for exactly one cycle, then IDLE. Counter cell reads 00 on the following cycle.
- IDLE: START=1 with STOP=0.
  - PRESET valid (each nibble <= 9): capture PRESET and AUTO, go to LOAD.
  - PRESET invalid: ERR=1 next cycle, stay in IDLE.
- LOAD: CNT_LD=1 and CNT_D=captured preset for one cycle, then RUN. The cell holds the preset on the next edge.
- RUN: CNT_EN=1, CNT_CAI=TICK (combinational pass-through), CNT_LD=0, CNT_CS=0. The cell wraps 00->99 on the same edge as CNT_CAO=1.
- Terminal count: CNT_CAO=1 sampled in RUN starts an EXPIRE pulse the next cycle for PULSE_W cycles. A new terminal count during a pulse restarts the width counter. Next state is RELOAD if the mode latch is 1, else CLEAR.
- RELOAD: same outputs as LOAD using the captured preset, then RUN. Period = preset+1 TICKs; preset 00 expires on every TICK.
- CNT_CAI=0 outside RUN, so TICKs in LOAD, RELOAD and CLEAR are dropped.
- STOP=1 in any state except CLEAR: next state CLEAR, no EXPIRE. If STOP and CNT_CAO coincide, STOP wins and EXPIRE is suppressed.
- START=1 in RUN or RELOAD with a valid PRESET: re-capture, go to LOAD (restart). With an invalid PRESET: ERR pulse, continue unchanged.
- START held high in IDLE after a single-shot completion retriggers: the next cycle goes to LOAD.
- CNT_Q is used only for the optional zero check; it never alters the counting sequence.

Optional Feature:
BCD_TMR_DROP_CNT_EN.
- Defined: adds output DROP_CNT[7:0], a binary count of TICKs that arrive while BUSY=1 and state is not RUN. It saturates at 255 and clears on START acceptance and reset. Adds output QZ_MISMATCH: a one-cycle pulse when CNT_CAO=1 in RUN but CNT_Q != 00.
- Undefined: both ports and their logic are absent; all other behaviour is identical.

Decomposition:
Package bcd_tmr_pkg holds:
- state enum (CLEAR, IDLE, LOAD, RUN, RELOAD)
- PW_W=4 pulse-counter width constant
- function is_bcd8(8-bit) returning nibble validity

One sub-module, bcd_tmr_pulse_stretch (retriggerable PULSE_W stretcher), instantiated once. The FSM stays in the top.

Test Plan:
- Reset release with RSTN low mid-RUN -> CNT_CS=1 for one cycle after release, then IDLE. All other outputs 0 throughout reset.
- PRESET=8'h03, AUTO=0, START, TICK every cycle -> CNT_LD one cycle with CNT_D=03. EXPIRE one cycle after the 4th RUN TICK, then CNT_CS pulse, BUSY=0.
- PRESET=8'h12, AUTO=1, PULSE_W=3 -> EXPIRE 3 cycles wide every 13 TICKs; CNT_D=12 on each RELOAD cycle; the TICK during RELOAD is dropped.
- PRESET=8'h1A, START -> ERR one cycle, no CNT_LD, state IDLE. Then PRESET=8'h00, START -> EXPIRE on the first RUN TICK.
- STOP asserted on the same cycle as CNT_CAO=1 -> no EXPIRE, CNT_CS next cycle, IDLE.
- With BCD_TMR_DROP_CNT_EN, TICK held high over 5 auto-reload periods -> DROP_CNT=5. Forcing CNT_Q=8'h07 with CNT_CAO=1 -> QZ_MISMATCH pulse.
